iltype_instr_decoder: RTL and testbench

- Receiving end of the I/L-type instruction stream driven into the sodor5 core's imem response path.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes them into fields (opcode class, rd, rs1, funct3, sign-extended imm).
- Checks each word against the I/L-type encoding rules and keeps per-class counters plus a sticky first-error capture.
- Sits beside the core in the sodor5_verif harness as a synthesizable stream decoder and monitor.

---
 rtl/iltype_instr_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_iltype_instr_decoder.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iltype_instr_decoder.sv
// I/L-type instruction stream decoder with a 2-entry elastic buffer.
// Keeps saturating per-class counters and captures the first illegal word.
module iltype_instr_decoder #(
   parameter int          CNT_W    = 16,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_class,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [2:0]       out_funct3,
   output logic [31:0]      out_imm,
   output logic [31:0]      out_instr,
   output logic [CNT_W-1:0] cnt_opimm,
   output logic [CNT_W-1:0] cnt_load,
   output logic [CNT_W-1:0] cnt_nop,
   output logic [CNT_W-1:0] cnt_illegal,
   output logic             err_sticky,
   output logic [31:0]      err_instr
);

   localparam logic [1:0] C_OPIMM = 2'd0;
   localparam logic [1:0] C_LOAD  = 2'd1;
   localparam logic [1:0] C_NOP   = 2'd2;
   localparam logic [1:0] C_ILL   = 2'd3;

   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic        in_fire;
   logic        out_fire;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  hi;
   logic        opimm_ok;
   logic        load_ok;
   logic [1:0]  in_class;

   logic [1:0]  main_class;
   logic [31:0] main_instr;
   logic [1:0]  skid_class;
   logic [31:0] skid_instr;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   assign opc = in_instr[6:0];
   assign f3  = in_instr[14:12];
   assign hi  = in_instr[31:25];

   always_comb begin
      opimm_ok = 1'b1;
      case (f3)
         3'd1:    opimm_ok = (hi == 7'b0000000);
         3'd5:    opimm_ok = (hi == 7'b0000000) ||
                             (hi == 7'b0100000);
         default: opimm_ok = 1'b1;
      endcase
   end

   assign load_ok = (f3 != 3'd3) && (f3 < 3'd6);

   // NOP must win over the generic OP-IMM match
   always_comb begin
      in_class = C_ILL;
      priority case (1'b1)
         (in_instr == NOP_WORD):
            in_class = C_NOP;
         (opc == OPC_OPIMM):
            in_class = opimm_ok ? C_OPIMM : C_ILL;
         (opc == OPC_LOAD):
            in_class = load_ok ? C_LOAD : C_ILL;
         default:
            in_class = C_ILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= EMPTY;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         EMPTY: if (in_fire) state_nx = ONE;
         ONE: begin
            if (in_fire && !out_fire)
               state_nx = FULL;
            else if (out_fire && !in_fire)
               state_nx = EMPTY;
         end
         FULL: if (out_fire) state_nx = ONE;
         default: state_nx = EMPTY;
      endcase
   end

   // Both flags come straight off the state flop, never off out_ready
   always_comb begin
      out_valid = 1'b0;
      in_ready  = 1'b1;
      unique case (state)
         EMPTY: begin
            out_valid = 1'b0;
            in_ready  = 1'b1;
         end
         ONE: begin
            out_valid = 1'b1;
            in_ready  = 1'b1;
         end
         FULL: begin
            out_valid = 1'b1;
            in_ready  = 1'b0;
         end
         default: begin
            out_valid = 1'b0;
            in_ready  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_class <= '0;
         main_instr <= '0;
         skid_class <= '0;
         skid_instr <= '0;
      end else begin
         if (state == FULL && out_fire) begin
            main_class <= skid_class;
            main_instr <= skid_instr;
         end else if (in_fire &&
                      (state == EMPTY || out_fire)) begin
            main_class <= in_class;
            main_instr <= in_instr;
         end
         if (in_fire && state == ONE && !out_fire) begin
            skid_class <= in_class;
            skid_instr <= in_instr;
         end
      end
   end

   assign out_class  = main_class;
   assign out_instr  = main_instr;
   assign out_rd     = main_instr[11:7];
   assign out_rs1    = main_instr[19:15];
   assign out_funct3 = main_instr[14:12];
   assign out_imm    = {{20{main_instr[31]}},
                        main_instr[31:20]};

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_opimm   <= '0;
         cnt_load    <= '0;
         cnt_nop     <= '0;
         cnt_illegal <= '0;
      end else if (out_fire) begin
         unique case (main_class)
            C_OPIMM:
               if (cnt_opimm != '1)
                  cnt_opimm <= cnt_opimm + 1'b1;
            C_LOAD:
               if (cnt_load != '1)
                  cnt_load <= cnt_load + 1'b1;
            C_NOP:
               if (cnt_nop != '1)
                  cnt_nop <= cnt_nop + 1'b1;
            default:
               if (cnt_illegal != '1)
                  cnt_illegal <= cnt_illegal + 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_sticky <= 1'b0;
         err_instr  <= '0;
      end else if (out_fire && main_class == C_ILL &&
                   !err_sticky) begin
         err_sticky <= 1'b1;
         err_instr  <= main_instr;
      end
   end

endmodule

// File: tb/tb_iltype_instr_decoder.sv
// Bench for iltype_instr_decoder: directed scenarios plus random
// traffic scored against a queue-based reference model.
module tb_iltype_instr_decoder;

   localparam int W = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_instr;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_class;
   logic [4:0]    out_rd;
   logic [4:0]    out_rs1;
   logic [2:0]    out_funct3;
   logic [31:0]   out_imm;
   logic [31:0]   out_instr;
   logic [W-1:0]  cnt_opimm;
   logic [W-1:0]  cnt_load;
   logic [W-1:0]  cnt_nop;
   logic [W-1:0]  cnt_illegal;
   logic          err_sticky;
   logic [31:0]   err_instr;

   always #5 clk = ~clk;

   iltype_instr_decoder #(.CNT_W(W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_rd(out_rd),
      .out_rs1(out_rs1), .out_funct3(out_funct3),
      .out_imm(out_imm), .out_instr(out_instr),
      .cnt_opimm(cnt_opimm), .cnt_load(cnt_load),
      .cnt_nop(cnt_nop), .cnt_illegal(cnt_illegal),
      .err_sticky(err_sticky), .err_instr(err_instr)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0]  q[$];
   logic [W-1:0] m_cnt [4];
   logic         m_err;
   logic [31:0]  m_err_w;

   bit           popped;
   bit           underflow = 0;
   logic [31:0]  got_w, exp_w, got_imm;
   logic [1:0]   got_c;
   logic [4:0]   got_rd, got_rs1;
   logic [2:0]   got_f3;

   function automatic logic [1:0] ref_class(input logic [31:0] w);
      logic [6:0] op;
      logic [2:0] fn;
      logic [6:0] top;
      op  = w[6:0];
      fn  = w[14:12];
      top = w[31:25];
      if (w == 32'h0000_0013) return 2'd2;
      if (op == 7'h13) begin
         if (fn == 3'd1 && top != 7'h00) return 2'd3;
         if (fn == 3'd5 && !(top inside {7'h00, 7'h20}))
            return 2'd3;
         return 2'd0;
      end
      if (op == 7'h03)
         return (fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                ? 2'd1 : 2'd3;
      return 2'd3;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] r;
      int          pick;
      r    = $urandom;
      pick = $urandom_range(0, 9);
      if (pick == 0) return 32'h0000_0013;
      if (pick <= 4) return {r[31:7], 7'h13};
      if (pick <= 7) return {r[31:7], 7'h03};
      if (pick == 8)
         return {(r[0] ? 7'h20 : 7'h00), r[24:15],
                 (r[1] ? 3'd5 : 3'd1), r[11:7], 7'h13};
      return r;
   endfunction

   // Advance one clock, updating the model; comparisons live in the tests
   task automatic tick();
      bit inf, outf;
      logic [1:0] c;
      inf    = in_valid && in_ready;
      outf   = out_valid && out_ready;
      popped = 0;
      if (reset) begin
         q.delete();
         foreach (m_cnt[i]) m_cnt[i] = '0;
         m_err   = 1'b0;
         m_err_w = '0;
      end else begin
         if (outf) begin
            popped  = 1;
            got_w   = out_instr;
            got_c   = out_class;
            got_imm = out_imm;
            got_rd  = out_rd;
            got_rs1 = out_rs1;
            got_f3  = out_funct3;
            if (q.size() == 0) begin
               underflow = 1;
               exp_w     = '0;
            end else begin
               exp_w = q.pop_front();
               c = ref_class(exp_w);
               if (m_cnt[c] != '1) m_cnt[c] = m_cnt[c] + 1'b1;
               if (c == 2'd3 && !m_err) begin
                  m_err   = 1'b1;
                  m_err_w = exp_w;
               end
            end
         end
         if (inf) q.push_back(in_instr);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_hs got v=%b r=%b exp v=0 r=1",
                  out_valid, in_ready);
      end
      total++;
      if ({cnt_opimm, cnt_load, cnt_nop, cnt_illegal} !== '0) begin
         bad++;
         $display("FAIL reset_cnt got %h %h %h %h exp 0",
                  cnt_opimm, cnt_load, cnt_nop, cnt_illegal);
      end
      total++;
      if (err_sticky !== 1'b0 || err_instr !== 32'h0 ||
          out_instr !== 32'h0 || out_class !== 2'd0 ||
          out_imm !== 32'h0) begin
         bad++;
         $display("FAIL reset_regs got err=%b ei=%h oi=%h exp 0",
                  err_sticky, err_instr, out_instr);
      end
   endtask

   task automatic test_nop();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h0000_0013;
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_class !== 2'd2) begin
         bad++;
         $display("FAIL nop_latency got v=%b c=%0d exp v=1 c=2",
                  out_valid, out_class);
      end
      tick();
      total++;
      if (cnt_nop !== 4'd1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL nop_count got cnt=%0d v=%b exp 1 0",
                  cnt_nop, out_valid);
      end
   endtask

   task automatic test_addi();
      // addi x1,x1,-1
      in_valid = 1'b1;
      in_instr = 32'hFFF0_8093;
      tick();
      in_valid = 1'b0;
      total++;
      if (out_class !== 2'd0 || out_rd !== 5'd1 ||
          out_rs1 !== 5'd1 || out_funct3 !== 3'd0) begin
         bad++;
         $display("FAIL addi_fields got c=%0d rd=%0d rs1=%0d f3=%0d",
                  out_class, out_rd, out_rs1, out_funct3);
      end
      total++;
      if (out_imm !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL addi_imm got %h exp ffffffff", out_imm);
      end
      tick();
   endtask

   task automatic test_shift_err();
      logic [31:0] w [3];
      logic [1:0]  c [3];
      w[0] = 32'h4000_D213; c[0] = 2'd0;
      w[1] = 32'h8000_D213; c[1] = 2'd3;
      w[2] = 32'h0000_B003; c[2] = 2'd3;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_instr = w[i];
         tick();
         total++;
         if (out_valid !== 1'b1 || out_class !== c[i]) begin
            bad++;
            $display("FAIL shift_class%0d got c=%0d exp %0d",
                     i, out_class, c[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      total++;
      if (err_sticky !== 1'b1 || err_instr !== 32'h8000_D213) begin
         bad++;
         $display("FAIL err_capture got s=%b w=%h exp 1 8000d213",
                  err_sticky, err_instr);
      end
      total++;
      if (cnt_illegal !== 4'd2) begin
         bad++;
         $display("FAIL err_count got %0d exp 2", cnt_illegal);
      end
   endtask

   task automatic test_load();
      // lbu x2,4(x1)
      in_valid = 1'b1;
      in_instr = 32'h0040_C103;
      tick();
      total++;
      if (out_class !== 2'd1 || out_funct3 !== 3'd4 ||
          out_imm !== 32'd4 || out_rd !== 5'd2 ||
          out_rs1 !== 5'd1) begin
         bad++;
         $display("FAIL lbu got c=%0d f3=%0d imm=%h rd=%0d",
                  out_class, out_funct3, out_imm, out_rd);
      end
      in_instr = 32'h0000_E003;
      tick();
      in_valid = 1'b0;
      total++;
      if (out_class !== 2'd3) begin
         bad++;
         $display("FAIL load_f3_6 got c=%0d exp 3", out_class);
      end
      tick();
      total++;
      if (err_instr !== 32'h8000_D213 || cnt_load !== 4'd1) begin
         bad++;
         $display("FAIL load_after got ei=%h cl=%0d exp 8000d213 1",
                  err_instr, cnt_load);
      end
   endtask

   task automatic test_stall();
      logic [31:0] w [3];
      w[0] = 32'h0050_0093;
      w[1] = 32'h0040_C103;
      w[2] = 32'h0000_0013;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = w[0];
      tick();
      in_instr = w[1];
      tick();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_instr !== w[0]) begin
         bad++;
         $display("FAIL stall_full got r=%b v=%b w=%h exp 0 1 %h",
                  in_ready, out_valid, out_instr, w[0]);
      end
      in_instr = w[2];
      repeat (3) tick();
      total++;
      if (in_ready !== 1'b0 || out_instr !== w[0] ||
          out_class !== 2'd0 || out_imm !== 32'd5) begin
         bad++;
         $display("FAIL stall_hold got r=%b w=%h imm=%h",
                  in_ready, out_instr, out_imm);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) in_valid = 1'b0;
         tick();
         total++;
         if (!popped || got_w !== w[i]) begin
            bad++;
            $display("FAIL stall_order%0d got p=%b w=%h exp %h",
                     i, popped, got_w, w[i]);
         end
         if (i == 0) begin
            total++;
            if (in_ready !== 1'b1) begin
               bad++;
               $display("FAIL stall_reassert got r=%b exp 1",
                        in_ready);
            end
         end
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_drain got v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_random();
      logic [31:0] e_imm;
      for (int i = 0; i < 304; i++) begin
         if (i < 300) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
         end
         in_instr = rand_word();
         total++;
         if (out_valid !== (q.size() != 0) ||
             in_ready !== (q.size() < 2)) begin
            bad++;
            $display("FAIL rand_occ%0d got v=%b r=%b n=%0d",
                     i, out_valid, in_ready, q.size());
         end
         tick();
         if (popped) begin
            e_imm = {{20{exp_w[31]}}, exp_w[31:20]};
            total++;
            if (got_w !== exp_w || got_c !== ref_class(exp_w) ||
                got_imm !== e_imm || got_rd !== exp_w[11:7] ||
                got_rs1 !== exp_w[19:15] ||
                got_f3 !== exp_w[14:12]) begin
               bad++;
               $display("FAIL rand_rec%0d got w=%h c=%0d exp w=%h c=%0d",
                        i, got_w, got_c, exp_w, ref_class(exp_w));
            end
         end
      end
      total++;
      if (cnt_opimm !== m_cnt[0] || cnt_load !== m_cnt[1] ||
          cnt_nop !== m_cnt[2] || cnt_illegal !== m_cnt[3]) begin
         bad++;
         $display("FAIL rand_cnt got %0d %0d %0d %0d exp %0d %0d %0d %0d",
                  cnt_opimm, cnt_load, cnt_nop, cnt_illegal,
                  m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
      end
      total++;
      if (err_sticky !== m_err || err_instr !== m_err_w) begin
         bad++;
         $display("FAIL rand_err got %b %h exp %b %h",
                  err_sticky, err_instr, m_err, m_err_w);
      end
   endtask

   task automatic test_saturation();
      logic [31:0] r;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         r        = $urandom;
         in_valid = 1'b1;
         in_instr = {r[31:20], 5'd3, 3'd0, 5'd2, 7'h13};
         tick();
      end
      in_valid = 1'b0;
      tick();
      total++;
      if (cnt_opimm !== 4'hF || cnt_opimm !== m_cnt[0]) begin
         bad++;
         $display("FAIL sat_opimm got %0d exp 15", cnt_opimm);
      end
      total++;
      if (cnt_nop !== m_cnt[2] || cnt_illegal !== m_cnt[3]) begin
         bad++;
         $display("FAIL sat_other got %0d %0d exp %0d %0d",
                  cnt_nop, cnt_illegal, m_cnt[2], m_cnt[3]);
      end
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h0040_C103;
      tick();
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre got v=%b exp 1", out_valid);
      end
      reset    = 1'b1;
      in_instr = 32'h0000_0013;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_hs got v=%b r=%b exp 0 1",
                  out_valid, in_ready);
      end
      total++;
      if ({cnt_opimm, cnt_load, cnt_nop, cnt_illegal} !== '0 ||
          err_sticky !== 1'b0 || err_instr !== 32'h0 ||
          out_instr !== 32'h0) begin
         bad++;
         $display("FAIL mid_regs got co=%0d s=%b ei=%h oi=%h exp 0",
                  cnt_opimm, err_sticky, err_instr, out_instr);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_discard got v=%b exp 0", out_valid);
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_instr  = '0;
      foreach (m_cnt[i]) m_cnt[i] = '0;
      m_err   = 1'b0;
      m_err_w = '0;
      @(negedge clk);
      test_reset();
      test_nop();
      test_addi();
      test_shift_err();
      test_load();
      test_stall();
      test_random();
      test_saturation();
      test_mid_reset();
      total++;
      if (underflow) begin
         bad++;
         $display("FAIL scoreboard got extra output record exp none");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
